// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, 2N/N -> 2N quotient, N remainder
module seq_divider #(
    parameter int N = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int CW = $clog2(2*N+1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [2*N-1:0] dividend_sr;
    logic [2*N-1:0] quotient_sr;
    logic [N-1:0]   divisor_r;
    logic [N:0]     partial;
    logic [CW-1:0]  count;

    logic           accept;
    logic           divisor_zero;
    logic [N+1:0]   shifted;
    logic [N+1:0]   trial;
    logic           trial_ok;
    logic [N:0]     partial_next;
    logic [2*N-1:0] quotient_next;
    logic [CW-1:0]  count_next;

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign accept       = in_valid & in_ready;
    assign divisor_zero = (divisor == '0);

    // One restoring step; the extra top bit of trial is the borrow/sign.
    always_comb begin
        shifted       = {partial, dividend_sr[2*N-1]};
        trial         = shifted - {2'b00, divisor_r};
        trial_ok      = ~trial[N+1];
        partial_next  = trial_ok ? trial[N:0] : shifted[N:0];
        quotient_next = {quotient_sr[2*N-2:0], trial_ok};
        count_next    = count - CW'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = divisor_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (count_next == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dividend_sr <= '0;
            quotient_sr <= '0;
            divisor_r   <= '0;
            partial     <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dividend_sr <= dividend;
                        divisor_r   <= divisor;
                        partial     <= '0;
                        quotient_sr <= '0;
                        count       <= CW'(2*N);
                        if (divisor_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend[N-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    dividend_sr <= {dividend_sr[2*N-2:0], 1'b0};
                    partial     <= partial_next;
                    quotient_sr <= quotient_next;
                    count       <= count_next;
                    // Final step: publish straight from the next-state values.
                    if (count_next == '0) begin
                        quotient  <= quotient_next;
                        remainder <= partial_next[N-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic reference
module tb_seq_divider;

    localparam int N = 10;
    localparam int W = 2*N;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   dividend;
    logic [N-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;

    int n_asserts;
    int n_fails;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one operation, waits for its result; lat = edges after the accept edge.
    task automatic run_op(input logic [W-1:0] dvd, input logic [N-1:0] dvs, input logic ordy,
                          output logic [W-1:0] q, output logic [N-1:0] r,
                          output logic dbz, output int lat);
        int guard;
        @(negedge clk);
        dividend  = dvd;
        divisor   = dvs;
        in_valid  = 1'b1;
        out_ready = ordy;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = N'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("result_valid", {63'd0, out_valid}, 64'd1);
        q   = quotient;
        r   = remainder;
        dbz = div_by_zero;
    endtask

    task automatic check_op(input string tag, input logic [W-1:0] dvd, input logic [N-1:0] dvs);
        logic [W-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           lat;
        logic [W-1:0] exp_q;
        logic [N-1:0] exp_r;
        run_op(dvd, dvs, 1'b1, q, r, dbz, lat);
        if (dvs == 0) begin
            exp_q = {W{1'b1}};
            exp_r = N'(dvd % (1 << N));
        end else begin
            exp_q = dvd / W'(dvs);
            exp_r = N'(dvd % W'(dvs));
        end
        check({tag, "_q"}, 64'(q), 64'(exp_q));
        check({tag, "_r"}, 64'(r), 64'(exp_r));
        check({tag, "_dbz"}, {63'd0, dbz}, {63'd0, (dvs == 0)});
        check({tag, "_lat"}, 64'(lat), (dvs == 0) ? 64'd0 : 64'(W));
    endtask

    initial begin
        logic [W-1:0] q, held_q, dvd;
        logic [N-1:0] r, held_r, dvs;
        logic         dbz;
        int           lat;
        int           seen;
        int unsigned  a, b;

        n_asserts = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        rst_n = 1'b1;

        check_op("d1000_7", W'(1000), N'(7));
        check_op("dmax_1023", W'(1048575), N'(1023));
        check_op("dmax_1", W'(1048575), N'(1));
        check_op("d12345_0", W'(12345), N'(0));
        check_op("d0_5", W'(0), N'(5));

        // Backpressure: result must hold while in_valid churns.
        run_op(W'(555555), N'(321), 1'b0, held_q, held_r, dbz, lat);
        check("bp_lat", 64'(lat), 64'(W));
        check("bp_q", 64'(held_q), 64'(555555 / 321));
        check("bp_r", 64'(held_r), 64'(555555 % 321));
        for (int i = 0; i < 15; i++) begin
            dividend = W'($urandom);
            divisor  = N'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
            check("bp_hold_q", 64'(quotient), 64'(held_q));
            check("bp_hold_r", 64'(remainder), 64'(held_r));
        end
        dividend  = W'(777777);
        divisor   = N'(99);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_ready", {63'd0, in_ready}, 64'd1);
        check("bp_idle_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("bp_pending_accepted", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("bp_pending_lat", 64'(lat), 64'(W));
        check("bp_pending_q", 64'(quotient), 64'(777777 / 99));
        check("bp_pending_r", 64'(remainder), 64'(777777 % 99));
        @(negedge clk);

        // Reset in the middle of a run discards the operation.
        dividend = W'(900001);
        divisor  = N'(13);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_quotient", 64'(quotient), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_result", 64'(seen), 64'd0);

        // Round trip: (a*b)/b == a.
        for (int i = 0; i < 200; i++) begin
            a   = $urandom_range(0, 1023);
            b   = $urandom_range(1, 1023);
            dvd = W'(a * b);
            run_op(dvd, N'(b), 1'b1, q, r, dbz, lat);
            check("rt_q", 64'(q), 64'(a));
            check("rt_r", 64'(r), 64'd0);
        end

        // Random pairs against the division invariant.
        for (int i = 0; i < 200; i++) begin
            dvd = W'($urandom);
            dvs = (i % 2 == 0) ? N'($urandom_range(1, 15)) : N'($urandom_range(1, 1023));
            run_op(dvd, dvs, 1'b1, q, r, dbz, lat);
            check("inv_sum", 64'(q) * 64'(dvs) + 64'(r), 64'(dvd));
            check("inv_r_lt_d", {63'd0, (r < dvs)}, 64'd1);
            check("inv_q", 64'(q), 64'(dvd / W'(dvs)));
            check("inv_lat", 64'(lat), 64'(W));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
